// File: rtl/dfh_chain_walker.sv
// Walks a Device Feature Header linked list through a 64-bit CSR read port and
// streams every header found with its address; stops on end-of-list or on error.
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | CSR read request presented, held until accepted
// WAIT   | read outstanding, response timer running
// EMIT   | DFH record presented, held until consumed, then next hop decided
// DONE   | one-cycle done pulse, err_code/dfh_count final
module dfh_chain_walker #(
  parameter int ADDR_W      = 20,
  parameter int MAX_DFH     = 16,
  parameter int TIMEOUT_CYC = 256,
  parameter int IDX_W       = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_code_o,
  output logic [IDX_W-1:0]  dfh_count_o,
  output logic              rd_req_valid_o,
  input  logic              rd_req_ready_i,
  output logic [ADDR_W-1:0] rd_req_addr_o,
  input  logic              rd_rsp_valid_i,
  input  logic [63:0]       rd_rsp_data_i,
  output logic              dfh_valid_o,
  input  logic              dfh_ready_i,
  output logic [ADDR_W-1:0] dfh_addr_o,
  output logic [63:0]       dfh_data_o,
  output logic [IDX_W-1:0]  dfh_idx_o
);

  localparam int SUM_W = ((ADDR_W > 24) ? ADDR_W : 24) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
  localparam logic [2:0] ERR_ZERO_OFF = 3'd2;
  localparam logic [2:0] ERR_ADDR_OVF = 3'd3;
  localparam logic [2:0] ERR_MAX_CNT  = 3'd4;
  localparam logic [2:0] ERR_MISALIGN = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  cur_addr_q;
  logic [IDX_W-1:0]   count_q;
  logic [TMR_W-1:0]   timer_q;
  logic [63:0]        data_q;
  logic [2:0]         err_q;
  logic               busy_q;
  logic               done_q;
  logic               req_valid_q;
  logic               dfh_valid_q;

  logic [SUM_W-1:0]   next_addr_d;
  logic [IDX_W-1:0]   count_d;
  logic               eol;
  logic               zero_off;
  logic               addr_bad;
  logic               at_max;
  logic               timer_exp;

  // The sum is kept wide enough for the full 24-bit offset so that no
  // offset bit above ADDR_W can be silently dropped before the carry check.
  assign next_addr_d = SUM_W'(cur_addr_q) + SUM_W'(data_q[39:16]);
  assign count_d     = count_q + IDX_W'(1);
  assign eol         = data_q[40];
  assign zero_off    = (data_q[39:16] == 24'd0);
  assign addr_bad    = (|next_addr_d[SUM_W-1:ADDR_W]) || (next_addr_d[2:0] != 3'd0);
  assign at_max      = (count_d == IDX_W'(MAX_DFH));
  assign timer_exp   = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      data_q      <= '0;
      err_q       <= ERR_OK;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      dfh_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            count_q <= '0;
            if (start_addr_i[2:0] != 3'd0) begin
              err_q   <= ERR_MISALIGN;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cur_addr_q  <= start_addr_i;
              err_q       <= ERR_OK;
              busy_q      <= 1'b1;
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (rd_req_ready_i) begin
            req_valid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response wins over an expiring timer in the same cycle.
          if (rd_rsp_valid_i) begin
            data_q      <= rd_rsp_data_i;
            dfh_valid_q <= 1'b1;
            state_q     <= S_EMIT;
          end else if (timer_exp) begin
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_EMIT: begin
          if (dfh_ready_i) begin
            dfh_valid_q <= 1'b0;
            count_q     <= count_d;
            if (eol || zero_off || addr_bad || at_max) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
              if (eol)           err_q <= ERR_OK;
              else if (zero_off) err_q <= ERR_ZERO_OFF;
              else if (addr_bad) err_q <= ERR_ADDR_OVF;
              else               err_q <= ERR_MAX_CNT;
            end else begin
              cur_addr_q  <= next_addr_d[ADDR_W-1:0];
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_code_o     = err_q;
  assign dfh_count_o    = count_q;
  assign rd_req_valid_o = req_valid_q;
  assign rd_req_addr_o  = cur_addr_q;
  assign dfh_valid_o    = dfh_valid_q;
  assign dfh_addr_o     = cur_addr_q;
  assign dfh_data_o     = data_q;
  assign dfh_idx_o      = count_q;

endmodule
